// File: rtl/add_round_key_seq.sv
// add_round_key_seq
//   Sequential AES AddRoundKey stage with an on-chip round-key bank.
//   Each accepted state vector is XORed lane-wise with the current round key.
//   The round index then steps up (encrypt) or down (decrypt) until the last round.
//   Optional macro ADD_ROUND_KEY_PIPE_EN registers the key read and the state input
//   ahead of the XOR, which gives a latency of 2 cycles instead of 1.
module add_round_key_seq #(
  parameter int DATA_W = 32,
  parameter int LANES  = 16,
  parameter int ROUNDS = 11,
  parameter int RND_W  = 4,
  parameter int LANE_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      decrypt,
  input  logic                      in_valid,
  input  logic [LANES*DATA_W-1:0]   state_in,
  input  logic                      key_we,
  input  logic [RND_W-1:0]          key_rnd,
  input  logic [LANE_W-1:0]         key_lane,
  input  logic [DATA_W-1:0]         key_wdata,
  output logic                      busy,
  output logic                      out_valid,
  output logic [LANES*DATA_W-1:0]   state_out,
  output logic [RND_W-1:0]          rnd_out,
  output logic                      done
);

  localparam int          VEC_W    = LANES * DATA_W;
  localparam int unsigned ROUNDS_U = ROUNDS;
  localparam int unsigned LANES_U  = LANES;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [RND_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;

  logic             accept;
  logic             is_last;
  logic             key_wr_ok;
  logic [VEC_W-1:0] key_vec;

  logic [VEC_W-1:0] state_out_q, state_out_d;
  logic [RND_W-1:0] rnd_out_q, rnd_out_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;

  // ------------------------------------------------------------------
  // Round-key bank: one array per lane, written one word at a time.
  // Reads are asynchronous on the round counter; the write lands on the
  // clock edge, so a same-cycle write to the round being read is seen
  // only from the next cycle on.
  // ------------------------------------------------------------------
  assign key_wr_ok = key_we
                   && (32'(key_rnd)  < ROUNDS_U)
                   && (32'(key_lane) < LANES_U);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_W-1:0] key_bank [ROUNDS];

    // Key write port; deliberately not reset so keys survive rst
    always_ff @(posedge clk) begin
      if (key_wr_ok && (key_lane == LANE_W'(gi))) begin
        key_bank[key_rnd] <= key_wdata;
      end
    end

    assign key_vec[gi*DATA_W +: DATA_W] = key_bank[cnt_q];
  end

  // ------------------------------------------------------------------
  // Round sequencing
  // ------------------------------------------------------------------
  assign is_last = dir_q ? (cnt_q == '0) : (cnt_q == LAST_RND);
  assign accept  = (fsm_q == ACTIVE) && in_valid && !run;

  // Next-state logic: run (re)starts a block, accepted inputs step the round
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (run) begin
      fsm_d = ACTIVE;
      dir_d = decrypt;
      cnt_d = decrypt ? LAST_RND : '0;
    end else if (accept) begin
      if (is_last) begin
        fsm_d = IDLE;
      end else if (dir_q) begin
        cnt_d = cnt_q - RND_W'(1);
      end else begin
        cnt_d = cnt_q + RND_W'(1);
      end
    end
  end

  // Sequencer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

`ifdef ADD_ROUND_KEY_PIPE_EN
  // ------------------------------------------------------------------
  // Two-stage datapath: stage 1 captures the input and the key it needs,
  // stage 2 performs the XOR into the output registers.
  // ------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [VEC_W-1:0] s1_state_q, s1_state_d;
  logic [VEC_W-1:0] s1_key_q, s1_key_d;
  logic [RND_W-1:0] s1_rnd_q, s1_rnd_d;
  logic             s1_last_q, s1_last_d;

  // Stage 1 capture; run clears it so an aborted block emits nothing
  always_comb begin
    s1_valid_d = accept;
    s1_state_d = s1_state_q;
    s1_key_d   = s1_key_q;
    s1_rnd_d   = s1_rnd_q;
    s1_last_d  = s1_last_q;
    if (accept) begin
      s1_state_d = state_in;
      s1_key_d   = key_vec;
      s1_rnd_d   = cnt_q;
      s1_last_d  = is_last;
    end
  end

  // Stage 2 XOR; the output registers hold their value between pulses
  always_comb begin
    state_out_d = state_out_q;
    rnd_out_d   = rnd_out_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    if (s1_valid_q && !run) begin
      state_out_d = s1_state_q ^ s1_key_q;
      rnd_out_d   = s1_rnd_q;
      out_valid_d = 1'b1;
      done_d      = s1_last_q;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_state_q <= '0;
      s1_key_q   <= '0;
      s1_rnd_q   <= '0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_state_q <= s1_state_d;
      s1_key_q   <= s1_key_d;
      s1_rnd_q   <= s1_rnd_d;
      s1_last_q  <= s1_last_d;
    end
  end

  // Still busy while the final round is in flight in stage 1
  assign busy = (fsm_q == ACTIVE) || s1_valid_q;
`else
  // ------------------------------------------------------------------
  // Single-stage datapath: XOR straight into the output registers.
  // ------------------------------------------------------------------

  // Output XOR; the output registers hold their value between pulses
  always_comb begin
    state_out_d = state_out_q;
    rnd_out_d   = rnd_out_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    if (accept) begin
      state_out_d = state_in ^ key_vec;
      rnd_out_d   = cnt_q;
      out_valid_d = 1'b1;
      done_d      = is_last;
    end
  end

  assign busy = (fsm_q == ACTIVE);
`endif

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_out_q <= '0;
      rnd_out_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_out_q <= state_out_d;
      rnd_out_q   <= rnd_out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign state_out = state_out_q;
  assign rnd_out   = rnd_out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_add_round_key_seq.sv
// tb_add_round_key_seq
//   Directed scenarios plus a randomized run, checked every cycle against a
//   queue-based reference model of the round-key XOR unit.
//   Define ADD_ROUND_KEY_PIPE_EN to check the 2-cycle latency build.
module tb_add_round_key_seq;
  localparam int DATA_W = 32;
  localparam int LANES  = 16;
  localparam int ROUNDS = 11;
  localparam int RND_W  = 4;
  localparam int LANE_W = 4;
  localparam int VW     = DATA_W * LANES;
`ifdef ADD_ROUND_KEY_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk;
  logic              rst;
  logic              run;
  logic              decrypt;
  logic              in_valid;
  logic [VW-1:0]     state_in;
  logic              key_we;
  logic [RND_W-1:0]  key_rnd;
  logic [LANE_W-1:0] key_lane;
  logic [DATA_W-1:0] key_wdata;
  logic              busy;
  logic              out_valid;
  logic [VW-1:0]     state_out;
  logic [RND_W-1:0]  rnd_out;
  logic              done;

  add_round_key_seq #(
    .DATA_W(DATA_W), .LANES(LANES), .ROUNDS(ROUNDS), .RND_W(RND_W), .LANE_W(LANE_W)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .decrypt(decrypt), .in_valid(in_valid),
    .state_in(state_in), .key_we(key_we), .key_rnd(key_rnd), .key_lane(key_lane),
    .key_wdata(key_wdata), .busy(busy), .out_valid(out_valid), .state_out(state_out),
    .rnd_out(rnd_out), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    int            rnd;
    bit            last;
    logic [VW-1:0] data;
  } item_t;

  logic [DATA_W-1:0] kmod [ROUNDS][LANES];
  item_t             pend[$];
  int                seq[$];
  bit                act;
  int                edge_n;
  bit                exp_ov, exp_dn, exp_busy;
  logic [VW-1:0]     exp_state;
  int                exp_rnd;

  // Applies one clock edge of the behavioural rules to the model
  task automatic model_edge();
    item_t         it;
    logic [VW-1:0] d;
    edge_n++;
    exp_ov = 1'b0;
    exp_dn = 1'b0;
    if (rst) begin
      act = 1'b0;
      seq.delete();
      pend.delete();
      exp_state = '0;
      exp_rnd = 0;
    end else begin
      if (run) begin
        pend.delete();
        seq.delete();
        act = 1'b1;
        for (int r = 0; r < ROUNDS; r++) seq.push_back(decrypt ? (ROUNDS - 1 - r) : r);
      end else if (act && in_valid) begin
        it.rnd  = seq.pop_front();
        it.last = (seq.size() == 0);
        if (it.last) act = 1'b0;
        it.due = edge_n + LAT - 1;
        for (int i = 0; i < LANES; i++)
          d[i*DATA_W +: DATA_W] = state_in[i*DATA_W +: DATA_W] ^ kmod[it.rnd][i];
        it.data = d;
        pend.push_back(it);
      end
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        it = pend.pop_front();
        exp_ov    = 1'b1;
        exp_dn    = it.last;
        exp_state = it.data;
        exp_rnd   = it.rnd;
      end
    end
    if (key_we && int'(key_rnd) < ROUNDS && int'(key_lane) < LANES)
      kmod[key_rnd][key_lane] = key_wdata;
    exp_busy = act || (pend.size() > 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid", VW'(out_valid), VW'(exp_ov));
    check("done",      VW'(done),      VW'(exp_dn));
    check("busy",      VW'(busy),      VW'(exp_busy));
    check("state_out", state_out,      exp_state);
    check("rnd_out",   VW'(rnd_out),   VW'(exp_rnd));
    if (out_valid)
      $display("out: rnd_out=%0d done=%0b lane0=%08h", rnd_out, done, state_out[DATA_W-1:0]);
  endtask

  // One cycle of stimulus; key_we is set up by the caller beforehand
  task automatic cyc(input bit r, input bit dec, input bit iv, input logic [VW-1:0] s);
    run = r;
    decrypt = dec;
    in_valid = iv;
    state_in = s;
    tick();
    run = 1'b0;
    in_valid = 1'b0;
    key_we = 1'b0;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = $urandom;
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic block(input bit dec);
    cyc(1'b1, dec, 1'b0, '0);
    repeat (ROUNDS) cyc(1'b0, 1'b0, 1'b1, rand_vec());
    idle(3);
  endtask

  logic [VW-1:0] ones;

  initial begin
    ones = '1;
    act = 1'b0;
    edge_n = 0;
    exp_state = '0;
    exp_rnd = 0;
    rst = 1'b1;
    run = 1'b0;
    decrypt = 1'b0;
    in_valid = 1'b0;
    state_in = '0;
    key_we = 1'b0;
    key_rnd = '0;
    key_lane = '0;
    key_wdata = '0;

    // Reset
    idle(2);
    rst = 1'b0;
    idle(1);

    // Key load with pattern 0x0000_0r0i, then out-of-range writes that must be dropped
    for (int r = 0; r < ROUNDS; r++) begin
      for (int i = 0; i < LANES; i++) begin
        key_we = 1'b1;
        key_rnd = RND_W'(r);
        key_lane = LANE_W'(i);
        key_wdata = DATA_W'((r << 8) | i);
        cyc(1'b0, 1'b0, 1'b0, '0);
      end
    end
    for (int r = ROUNDS; r < (1 << RND_W); r++) begin
      key_we = 1'b1;
      key_rnd = RND_W'(r);
      key_lane = '0;
      key_wdata = 32'hDEAD_BEEF;
      cyc(1'b0, 1'b0, 1'b0, '0);
    end

    // Encrypt with all-ones state, then decrypt
    cyc(1'b1, 1'b0, 1'b0, '0);
    repeat (ROUNDS) cyc(1'b0, 1'b0, 1'b1, ones);
    idle(3);
    cyc(1'b1, 1'b1, 1'b0, '0);
    repeat (ROUNDS) cyc(1'b0, 1'b0, 1'b1, ones);
    idle(3);

    // Gapped input 1,0,0,1 then the rest of the block
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, rand_vec());
    idle(2);
    repeat (ROUNDS - 1) cyc(1'b0, 1'b0, 1'b1, rand_vec());
    idle(3);

    // in_valid while idle, then restart at round 5 with in_valid also high
    repeat (3) cyc(1'b0, 1'b0, 1'b1, rand_vec());
    cyc(1'b1, 1'b0, 1'b0, '0);
    repeat (5) cyc(1'b0, 1'b0, 1'b1, rand_vec());
    cyc(1'b1, 1'b0, 1'b1, rand_vec());
    repeat (ROUNDS) cyc(1'b0, 1'b0, 1'b1, rand_vec());
    idle(3);

    // run and in_valid together while idle
    cyc(1'b1, 1'b1, 1'b1, rand_vec());
    repeat (ROUNDS) cyc(1'b0, 1'b0, 1'b1, rand_vec());
    idle(3);

    // Key hazard: rewrite key[3][0] in the cycle round 3 is consumed
    cyc(1'b1, 1'b0, 1'b0, '0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, rand_vec());
    key_we = 1'b1;
    key_rnd = RND_W'(3);
    key_lane = '0;
    key_wdata = 32'hA5A5_A5A5;
    cyc(1'b0, 1'b0, 1'b1, ones);
    repeat (ROUNDS - 4) cyc(1'b0, 1'b0, 1'b1, rand_vec());
    idle(3);
    block(1'b0);

    // Reset at round 4, then a fresh block with the retained keys
    cyc(1'b1, 1'b0, 1'b0, '0);
    repeat (4) cyc(1'b0, 1'b0, 1'b1, rand_vec());
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, rand_vec());
    rst = 1'b0;
    block(1'b0);
    block(1'b1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) begin
        key_we = 1'b1;
        key_rnd = RND_W'($urandom_range(0, (1 << RND_W) - 1));
        key_lane = LANE_W'($urandom_range(0, LANES - 1));
        key_wdata = $urandom;
      end
      cyc($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0, rand_vec());
    end
    rst = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_round_key_seq.md
Name: add_round_key_seq

Overview:
- Parametrised, sequential successor to the combinational AES AddRoundKey unit for the Versat datapath.
- Holds an on-chip round-key bank of ROUNDS x LANES words and steps through rounds automatically.
- Each accepted state vector is XORed with the current round key; the result is registered; the round index advances forward (encrypt) or backward (decrypt).
- Sits between the SubBytes/ShiftRows/MixColumns units and the state memory; replaces the fixed 16-lane XOR.

Parameters:
- DATA_W, 32, width of one state/key lane.
- LANES, 16, lanes per state vector.
- ROUNDS, 11, round keys stored (11/13/15 for AES-128/192/256).
- RND_W, 4, round index width; must satisfy 2^RND_W >= ROUNDS.
- LANE_W, 4, lane index width; must satisfy 2^LANE_W >= LANES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  single-cycle pulse; starts a new block and loads the round counter.
- decrypt  in  1  sampled on run; 0 = rounds ascend from 0, 1 = rounds descend from ROUNDS-1.
- in_valid  in  1  state_in valid this cycle.
- state_in  in  LANES*DATA_W  state vector; lane i = bits [i*DATA_W +: DATA_W].
- key_we  in  1  key bank write enable.
- key_rnd  in  RND_W  key bank write round index.
- key_lane  in  LANE_W  key bank write lane index.
- key_wdata  in  DATA_W  key word to write.
- busy  out  1  block in progress.
- out_valid  out  1  state_out valid.
- state_out  out  LANES*DATA_W  state_in XOR round key, registered.
- rnd_out  out  RND_W  round index used for the current state_out.
- done  out  1  high with the out_valid of the final round.

Behaviour:
- Reset: busy=0, out_valid=0, done=0, state_out=0, rnd_out=0, round counter=0, FSM=IDLE. The key bank is NOT cleared by rst.
- FSM IDLE -> ACTIVE on run:
  - The round counter loads 0 (decrypt=0) or ROUNDS-1 (decrypt=1).
  - The direction is latched.
  - busy=1 from the next cycle.
- In ACTIVE, each in_valid cycle:
  - state_out <= state_in ^ key[cnt] per lane.
  - rnd_out <= cnt; out_valid <= 1 on the next edge (latency 1).
  - cnt steps +1 (encrypt) or -1 (decrypt).
- The last round is cnt == ROUNDS-1 (encrypt) or cnt == 0 (decrypt). Accepting it sets done=1 together with out_valid, and the FSM returns to IDLE (busy=0 the same edge).
- out_valid and done are single-cycle pulses, one per accepted input; there is no backpressure.
- in_valid while IDLE: ignored, no output, no counter change.
- run while ACTIVE: aborts the current block and restarts the counter per decrypt. If in_valid is also high that cycle, the input is ignored; the first post-restart input uses the new start round.
- run and in_valid together while IDLE: the block starts and in_valid is ignored that cycle.
- Key write is independent of the FSM and allowed at any time.
  - A write to the round being read in the same cycle takes effect next cycle; the current XOR uses the old key.
  - Writes with key_rnd >= ROUNDS or key_lane >= LANES are dropped.
- rst mid-block: immediate return to IDLE with reset output values; key contents are preserved.
- No arithmetic beyond bitwise XOR; the counter never wraps past its bounds because the FSM leaves ACTIVE at the last round.

Optional Feature:
- ADD_ROUND_KEY_PIPE_EN defined:
  - Adds a register stage on the key read and the state input before the XOR, so latency is 2 cycles.
  - out_valid, done and rnd_out are delayed to match.
  - busy stays high until the final output's out_valid cycle.
  - run mid-block flushes both stages; nothing in flight is output.
- Undefined: single-stage behaviour as above (latency 1).

Test Plan:
- Key load/encrypt: load key[r][i] = {r,i} pattern (0x0000_0r0i); run, decrypt=0; 11 in_valid cycles with state_in lane i = 0xFFFF_FFFF.
  - Required: rnd_out 0..10; each lane = ~key[r][i]; done only with rnd_out=10; busy low after.
- Decrypt order: same keys, run, decrypt=1.
  - Required: rnd_out 10,9..0; done at rnd_out=0.
- Gapped input: in_valid toggled 1,0,0,1 during a block.
  - Required: out_valid only one cycle after each accepted input; rnd_out consecutive (0,1).
- Restart/idle: in_valid while IDLE gives no out_valid. Run at round 5, then run again.
  - Required: next output rnd_out=0; no done from the aborted block.
- Key hazard: write key[3][0]=0xA5A5_A5A5 in the same cycle round 3 is consumed, old value 0x0000_0300.
  - Required: lane0 = state ^ 0x0000_0300. The next block's round 3 uses 0xA5A5_A5A5.
- Reset: assert rst at round 4.
  - Required: next cycle busy=0, out_valid=0, state_out=0. A new block reuses the previously loaded keys unchanged.
  - Repeat all scenarios with ADD_ROUND_KEY_PIPE_EN defined, checking latency 2.
